// File: rtl/rat_path_player.sv
// Replays a queue of 2-bit maze moves as an (X,Y) walk on a valid/ready stream.
// Each step is fetched, bounds-checked and then presented until the sink accepts it.
module rat_path_player #(
  parameter int N       = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             q_empty,
  input  logic [1:0]       q_data,
  output logic             q_dequeue,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [1:0]       move_dir,
  output logic [N-1:0]     pos_x,
  output logic [N-1:0]     pos_y,
  output logic [LEN_W-1:0] step_count,
  output logic             busy,
  output logic             replay_done,
  output logic             oob_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    FIN,
    ERR
  } state_t;

  localparam logic [N-1:0]     X0     = N'(START_X);
  localparam logic [N-1:0]     Y0     = N'(START_Y);
  localparam logic [N-1:0]     MAX_C  = '1;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic run_d;
  logic run_rise;
  logic oob_step;
  logic [N-1:0] nx, ny;
  logic load_start, take_step, set_oob, accept;

  assign run_rise = run & ~run_d;

  // Candidate position for the queue head; an edge step flags instead of wrapping.
  always_comb begin
    nx = pos_x;
    ny = pos_y;
    oob_step = 1'b0;
    case (q_data)
      2'b00: if (pos_x == MAX_C) oob_step = 1'b1; else nx = pos_x + N'(1);
      2'b11: if (pos_x == '0)    oob_step = 1'b1; else nx = pos_x - N'(1);
      2'b01: if (pos_y == MAX_C) oob_step = 1'b1; else ny = pos_y + N'(1);
      2'b10: if (pos_y == '0)    oob_step = 1'b1; else ny = pos_y - N'(1);
    endcase
  end

  always_comb begin
    state_nxt   = state;
    q_dequeue   = 1'b0;
    move_valid  = 1'b0;
    busy        = 1'b1;
    replay_done = 1'b0;
    load_start  = 1'b0;
    take_step   = 1'b0;
    set_oob     = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run_rise) begin
          load_start = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        if (q_empty) begin
          state_nxt = FIN;
        end else begin
          q_dequeue = 1'b1;
          if (oob_step) begin
            set_oob   = 1'b1;
            state_nxt = ERR;
          end else begin
            take_step = 1'b1;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        move_valid = 1'b1;
        if (move_ready) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FIN: begin
        replay_done = 1'b1;
        state_nxt   = IDLE;
      end
      ERR: begin
        if (run_rise) begin
          load_start = 1'b1;
          state_nxt  = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The queue must not lose an entry on an edge where reset discards the step.
    if (rst) q_dequeue = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_d      <= 1'b0;
      pos_x      <= X0;
      pos_y      <= Y0;
      move_dir   <= 2'b00;
      step_count <= '0;
      oob_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      run_d <= run;
      if (load_start) begin
        pos_x      <= X0;
        pos_y      <= Y0;
        step_count <= '0;
        oob_err    <= 1'b0;
      end
      if (take_step) begin
        move_dir <= q_data;
        pos_x    <= nx;
        pos_y    <= ny;
      end
      if (set_oob) oob_err <= 1'b1;
      if (accept && step_count != CNT_MAX) step_count <= step_count + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_rat_path_player.sv
// Directed and randomized replays of rat_path_player against a walk model
// that computes expected moves from start point, maze size and path.
module tb_rat_path_player;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_run = 1'b0, a_q_empty = 1'b1, a_move_ready = 1'b0;
  logic [1:0] a_q_data = 2'b00;
  logic a_q_dequeue, a_move_valid, a_busy, a_replay_done, a_oob_err;
  logic [1:0] a_move_dir;
  logic [3:0] a_pos_x, a_pos_y;
  logic [7:0] a_step_count;

  logic b_run = 1'b0, b_q_empty = 1'b1, b_move_ready = 1'b0;
  logic [1:0] b_q_data = 2'b00;
  logic b_q_dequeue, b_move_valid, b_busy, b_replay_done, b_oob_err;
  logic [1:0] b_move_dir;
  logic [1:0] b_pos_x, b_pos_y;
  logic [7:0] b_step_count;

  rat_path_player #(.N(4), .START_X(0), .START_Y(0), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .run(a_run), .q_empty(a_q_empty), .q_data(a_q_data),
    .q_dequeue(a_q_dequeue), .move_ready(a_move_ready), .move_valid(a_move_valid),
    .move_dir(a_move_dir), .pos_x(a_pos_x), .pos_y(a_pos_y), .step_count(a_step_count),
    .busy(a_busy), .replay_done(a_replay_done), .oob_err(a_oob_err)
  );

  rat_path_player #(.N(2), .START_X(3), .START_Y(3), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .run(b_run), .q_empty(b_q_empty), .q_data(b_q_data),
    .q_dequeue(b_q_dequeue), .move_ready(b_move_ready), .move_valid(b_move_valid),
    .move_dir(b_move_dir), .pos_x(b_pos_x), .pos_y(b_pos_y), .step_count(b_step_count),
    .busy(b_busy), .replay_done(b_replay_done), .oob_err(b_oob_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sel = 0;
  int cycle = 0;

  logic [1:0] path[$];
  int rd_idx = 0;

  logic ob_valid, ob_deq, ob_busy, ob_done, ob_oob;
  logic [1:0] ob_dir;
  int ob_x, ob_y, ob_cnt;

  int acc_x[$], acc_y[$], acc_d[$];
  int deq_count, done_seen, first_valid, done_cycle, last_accept, oob_at_1;
  bit stall_prev = 0;
  logic [1:0] prev_dir;
  int prev_x, prev_y;

  int exp_x[$], exp_y[$], exp_d[$];
  int exp_oob;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample, log stream events, then pop on the rising edge.
  task automatic applyStimulus(input logic run_v, input logic ready_v, input logic rst_v);
    bit empty;
    @(negedge clk);
    rst = rst_v;
    empty = (rd_idx >= path.size());
    if (sel == 0) begin
      a_run = run_v; a_move_ready = ready_v; a_q_empty = empty;
      a_q_data = empty ? 2'b00 : path[rd_idx];
      b_run = 1'b0; b_move_ready = 1'b0; b_q_empty = 1'b1; b_q_data = 2'b00;
    end else begin
      b_run = run_v; b_move_ready = ready_v; b_q_empty = empty;
      b_q_data = empty ? 2'b00 : path[rd_idx];
      a_run = 1'b0; a_move_ready = 1'b0; a_q_empty = 1'b1; a_q_data = 2'b00;
    end
    #1;
    if (sel == 0) begin
      ob_valid = a_move_valid; ob_deq = a_q_dequeue; ob_busy = a_busy; ob_done = a_replay_done;
      ob_oob = a_oob_err; ob_dir = a_move_dir; ob_x = int'(a_pos_x); ob_y = int'(a_pos_y);
      ob_cnt = int'(a_step_count);
    end else begin
      ob_valid = b_move_valid; ob_deq = b_q_dequeue; ob_busy = b_busy; ob_done = b_replay_done;
      ob_oob = b_oob_err; ob_dir = b_move_dir; ob_x = int'(b_pos_x); ob_y = int'(b_pos_y);
      ob_cnt = int'(b_step_count);
    end
    cycle++;
    if (stall_prev && !rst_v) begin
      checkOutput("valid_held", ob_valid, 1);
      checkOutput("dir_held", ob_dir, prev_dir);
      checkOutput("x_held", ob_x, prev_x);
      checkOutput("y_held", ob_y, prev_y);
    end
    stall_prev = ob_valid && !ready_v && !rst_v;
    prev_dir = ob_dir; prev_x = ob_x; prev_y = ob_y;
    if (ob_valid && first_valid < 0) first_valid = cycle;
    if (ob_valid && ready_v && !rst_v) begin
      acc_x.push_back(ob_x); acc_y.push_back(ob_y); acc_d.push_back(int'(ob_dir));
      last_accept = cycle;
    end
    if (ob_done) begin done_seen++; done_cycle = cycle; end
    if (cycle == 1) oob_at_1 = int'(ob_oob);
    if (ob_deq) deq_count++;
    @(posedge clk);
    if (ob_deq && !empty) rd_idx++;
  endtask

  // Walk the path from the start point; the first step that leaves the maze ends it.
  task automatic model_path(input int sx, input int sy, input int nbits);
    int x, y, nx, ny, mx;
    exp_x.delete(); exp_y.delete(); exp_d.delete();
    exp_oob = 0;
    x = sx; y = sy; mx = (1 << nbits) - 1;
    for (int i = 0; i < path.size() && exp_oob == 0; i++) begin
      nx = x; ny = y;
      case (path[i])
        2'b00: nx = x + 1;
        2'b11: nx = x - 1;
        2'b01: ny = y + 1;
        default: ny = y - 1;
      endcase
      if (nx < 0 || nx > mx || ny < 0 || ny > mx) exp_oob = 1;
      else begin
        exp_x.push_back(nx); exp_y.push_back(ny); exp_d.push_back(int'(path[i]));
        x = nx; y = ny;
      end
    end
  endtask

  task automatic begin_replay();
    acc_x.delete(); acc_y.delete(); acc_d.delete();
    deq_count = 0; done_seen = 0; first_valid = -1; done_cycle = -1;
    last_accept = -1; oob_at_1 = -1; cycle = -1; rd_idx = 0;
  endtask

  task automatic finish_replay(input int pct, input int budget);
    bit ended;
    ended = 0;
    for (int k = 0; k < budget && !ended; k++) begin
      applyStimulus(1'b0, ($urandom_range(99) < pct), 1'b0);
      if (ob_done || (ob_oob && cycle >= 1)) ended = 1;
    end
    checkOutput("replay_terminates", ended, 1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic run_replay(input int pct, input int budget);
    begin_replay();
    applyStimulus(1'b1, 1'b1, 1'b0);
    finish_replay(pct, budget);
  endtask

  task automatic run_check(input int sx, input int sy, input int nbits);
    int n, lx, ly;
    model_path(sx, sy, nbits);
    n = exp_x.size();
    checkOutput("n_moves", acc_x.size(), n);
    for (int i = 0; i < n && i < acc_x.size(); i++) begin
      checkOutput("move_dir", acc_d[i], exp_d[i]);
      checkOutput("move_x", acc_x[i], exp_x[i]);
      checkOutput("move_y", acc_y[i], exp_y[i]);
    end
    checkOutput("n_dequeues", deq_count, n + exp_oob);
    checkOutput("step_count", ob_cnt, (n > 255) ? 255 : n);
    checkOutput("oob_err", ob_oob, exp_oob);
    checkOutput("busy_after", ob_busy, exp_oob);
    checkOutput("done_pulses", done_seen, (exp_oob != 0) ? 0 : 1);
    lx = (n > 0) ? exp_x[n-1] : sx;
    ly = (n > 0) ? exp_y[n-1] : sy;
    checkOutput("final_x", ob_x, lx);
    checkOutput("final_y", ob_y, ly);
  endtask

  initial begin
    // Reset state of both instances.
    sel = 0; path.delete(); begin_replay();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", ob_valid, 0);
    checkOutput("rst_deq", ob_deq, 0);
    checkOutput("rst_busy", ob_busy, 0);
    checkOutput("rst_done", ob_done, 0);
    checkOutput("rst_oob", ob_oob, 0);
    checkOutput("rst_dir", ob_dir, 0);
    checkOutput("rst_cnt", ob_cnt, 0);
    checkOutput("rst_x", ob_x, 0);
    checkOutput("rst_y", ob_y, 0);
    sel = 1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_b_x", ob_x, 3);
    checkOutput("rst_b_y", ob_y, 3);
    sel = 0;

    // Normal replay {00,00,01}.
    path = '{2'b00, 2'b00, 2'b01};
    run_replay(100, 50);
    run_check(0, 0, 4);
    checkOutput("first_valid_latency", first_valid, 2);
    checkOutput("done_after_accept", done_cycle - last_accept, 2);
    checkOutput("normal_end_x", ob_x, 2);
    checkOutput("normal_end_y", ob_y, 1);

    // Empty queue.
    path.delete();
    run_replay(100, 20);
    run_check(0, 0, 4);
    checkOutput("empty_no_valid", first_valid, -1);
    checkOutput("empty_done_latency", done_cycle, 2);

    // Backpressure on the first move, with a run pulse that must be ignored.
    path = '{2'b00, 2'b00};
    begin_replay();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      applyStimulus((c == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      checkOutput("bp_valid", ob_valid, 1);
      checkOutput("bp_x", ob_x, 1);
      checkOutput("bp_one_deq", deq_count, 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_count_after_accept", ob_cnt, 1);
    finish_replay(100, 50);
    run_check(0, 0, 4);

    // Out-of-bounds first step, then restart from the error state.
    path = '{2'b11, 2'b00};
    run_replay(100, 50);
    run_check(0, 0, 4);
    checkOutput("oob_no_valid", first_valid, -1);
    path = '{2'b00, 2'b01};
    run_replay(100, 50);
    run_check(0, 0, 4);
    checkOutput("restart_clears_oob", oob_at_1, 0);
    checkOutput("restart_latency", first_valid, 2);

    // Corner of a 4x4 maze.
    sel = 1;
    path = '{2'b10, 2'b00};
    run_replay(100, 50);
    run_check(3, 3, 2);
    checkOutput("edge_hold_x", ob_x, 3);
    checkOutput("edge_hold_y", ob_y, 2);
    sel = 0;

    // Reset while a move is presented.
    path = '{2'b00, 2'b01, 2'b00};
    begin_replay();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("emit_before_rst", ob_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_valid", ob_valid, 0);
    checkOutput("mid_rst_busy", ob_busy, 0);
    checkOutput("mid_rst_cnt", ob_cnt, 0);
    checkOutput("mid_rst_x", ob_x, 0);
    checkOutput("mid_rst_y", ob_y, 0);
    checkOutput("mid_rst_deqs", deq_count, 1);

    // Reset while fetching must not pop.
    path = '{2'b00};
    begin_replay();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("fetch_rst_no_deq", ob_deq, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fetch_rst_idle", ob_busy, 0);
    checkOutput("fetch_rst_deqs", deq_count, 0);

    // Step counter saturation on a long back-and-forth path.
    path.delete();
    for (int i = 0; i < 300; i++) path.push_back((i % 2 == 0) ? 2'b00 : 2'b11);
    run_replay(100, 2000);
    run_check(0, 0, 4);

    // Random paths with random sink stalls on both instances.
    for (int t = 0; t < 12; t++) begin
      int len, pct;
      sel = (t % 3 == 2) ? 1 : 0;
      len = $urandom_range(0, 20);
      pct = $urandom_range(30, 100);
      path.delete();
      for (int i = 0; i < len; i++) path.push_back(2'($urandom_range(0, 3)));
      run_replay(pct, 40 * len + 40);
      if (sel == 0) run_check(0, 0, 4);
      else run_check(3, 3, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
